// File: rtl/pkt_flit_injector.sv
// pkt_flit_injector
//   Accepts one whole packet per valid/ready handshake from the node packet
//   queue. It serialises the packet into HEAD/BODY/TAIL (or HEADTAIL) flits and
//   sends them to the router local input port. Credit-based flow control
//   guarantees that the router has buffer space for every flit sent.
// Ports
//   clk, arst_n      clock, asynchronous active-low reset
//   pkt_valid/ready  packet handshake from the queue
//   pkt_dst_x/y      destination coordinates
//   pkt_len          payload flit count, clamped to MAX_FLITS
//   pkt_payload      payload word i at [i*DATA_W +: DATA_W]
//   flit_valid       a flit is transferred this cycle
//   flit_type        00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL
//   flit_data        flit contents
//   credit_in        router freed one buffer slot
//   tx_pkt_cnt       count of fully injected packets (wraps)
//   err              sticky: credit overflow or oversize pkt_len
module pkt_flit_injector #(
  parameter  int SX        = 0,
  parameter  int SY        = 0,
  parameter  int COORD_W   = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_FLITS = 4,
  parameter  int BUF_DEPTH = 4,
  localparam int LEN_W     = $clog2(MAX_FLITS + 1)
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [COORD_W-1:0]            pkt_dst_x,
  input  logic [COORD_W-1:0]            pkt_dst_y,
  input  logic [LEN_W-1:0]              pkt_len,
  input  logic [MAX_FLITS*DATA_W-1:0]   pkt_payload,
  output logic                          flit_valid,
  output logic [1:0]                    flit_type,
  output logic [DATA_W-1:0]             flit_data,
  input  logic                          credit_in,
  output logic [15:0]                   tx_pkt_cnt,
  output logic                          err
);

  localparam int CRD_W = $clog2(BUF_DEPTH + 1);

  if (DATA_W < 4*COORD_W + LEN_W) begin : g_width_check
    $error("pkt_flit_injector: DATA_W too small for head flit fields");
  end

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

  state_t                        state;
  logic [COORD_W-1:0]            dst_x_q, dst_y_q;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              rem_q;    // payload flits still to send
  logic [MAX_FLITS*DATA_W-1:0]   pay_q;    // current payload word is always the low word
  logic [CRD_W-1:0]              credits;

  logic                          send, last, accept;
  logic [LEN_W-1:0]              len_clamp;
  logic [DATA_W-1:0]             head_data;

  assign send      = (state != S_IDLE) && (credits != '0);
  assign last      = send && (((state == S_HEAD) && (len_q == '0)) ||
                              ((state == S_BODY) && (rem_q == LEN_W'(1))));
  assign pkt_ready = (state == S_IDLE) || last;
  assign accept    = pkt_valid && pkt_ready;
  assign len_clamp = (pkt_len > LEN_W'(MAX_FLITS)) ? LEN_W'(MAX_FLITS) : pkt_len;
  assign flit_valid = send;

  always_comb begin
    head_data = '0;
    head_data[COORD_W-1:0]           = dst_x_q;
    head_data[2*COORD_W-1:COORD_W]   = dst_y_q;
    head_data[3*COORD_W-1:2*COORD_W] = COORD_W'(SX);
    head_data[4*COORD_W-1:3*COORD_W] = COORD_W'(SY);
    head_data[4*COORD_W +: LEN_W]    = len_q;
  end

  always_comb begin
    flit_type = 2'b00;
    flit_data = '0;
    if (send) begin
      if (state == S_HEAD) begin
        flit_type = (len_q == '0) ? 2'b11 : 2'b00;
        flit_data = head_data;
      end else begin
        flit_type = (rem_q == LEN_W'(1)) ? 2'b10 : 2'b01;
        flit_data = pay_q[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      pay_q      <= '0;
      credits    <= CRD_W'(BUF_DEPTH);
      tx_pkt_cnt <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) state <= S_HEAD;
        S_HEAD: begin
          if (send) begin
            if (len_q == '0) state <= accept ? S_HEAD : S_IDLE;
            else             state <= S_BODY;
          end
        end
        S_BODY: begin
          if (send) begin
            if (rem_q == LEN_W'(1)) begin
              state <= accept ? S_HEAD : S_IDLE;
            end else begin
              rem_q <= rem_q - LEN_W'(1);
              pay_q <= pay_q >> DATA_W;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Accept only happens in IDLE or on a last flit, so it never collides
      // with the payload shift above.
      if (accept) begin
        dst_x_q <= pkt_dst_x;
        dst_y_q <= pkt_dst_y;
        len_q   <= len_clamp;
        rem_q   <= len_clamp;
        pay_q   <= pkt_payload;
        if (pkt_len > LEN_W'(MAX_FLITS)) err <= 1'b1;
      end

      if (send && !credit_in) begin
        credits <= credits - CRD_W'(1);
      end else if (credit_in && !send) begin
        if (credits == CRD_W'(BUF_DEPTH)) err <= 1'b1;
        else                              credits <= credits + CRD_W'(1);
      end

      if (last) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
    end
  end

endmodule
